// File: rtl/hsn_pkg.sv
// hsn_pkg: shared constants and types for the HSN frame scheduler
package hsn_pkg;
    localparam int HSN_LAT = 9;
    localparam int HSN_N_REQ = 4;
    typedef logic [$clog2(HSN_N_REQ)-1:0] id_t;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} sched_state_t;
endpackage

// File: rtl/hsn_sched_rr_arbiter.sv
// rr_arbiter: rotating-priority find-first starting at ptr
module rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int IW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    idx
);
    logic [IW-1:0] k;
    logic found;
    always_comb begin
        idx = '0;
        found = 1'b0;
        k = '0;
        for (int i = 0; i < N_REQ; i++) begin
            k = IW'((int'(ptr) + i) % N_REQ);
            if (!found && req[k]) begin
                found = 1'b1;
                idx = k;
            end
        end
        grant = found ? N_REQ'(1) << idx : '0;
    end
endmodule

// File: rtl/hsn_sched.sv
// hsn_sched: round-robin frame scheduler sharing one HSN pipeline, draining before direction changes
module hsn_sched
    import hsn_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N_INPUTS = 8,
    parameter int N_REQ = 4,
    parameter int LAT = HSN_LAT
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N_REQ-1:0]                   req_valid,
    input  logic [N_REQ-1:0]                   req_dir,
    input  logic [N_REQ*N_INPUTS*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]                   req_ready,
    output logic [N_INPUTS*DATA_WIDTH-1:0]     hsn_data_in,
    output logic                               hsn_dir,
    output logic                               hsn_en,
    input  logic [N_INPUTS*DATA_WIDTH-1:0]     hsn_data_out,
    output logic                               res_valid,
    input  logic                               res_ready,
    output logic [$clog2(N_REQ)-1:0]           res_id,
    output logic                               res_dir,
    output logic [N_INPUTS*DATA_WIDTH-1:0]     res_data
);
    localparam int FW = N_INPUTS * DATA_WIDTH;
    localparam int IW = $clog2(N_REQ);
    localparam int OW = $clog2(LAT + 1);

    sched_state_t state, state_n;
    logic [IW-1:0] ptr, lg, g, gsel;
    logic [N_REQ-1:0] gnt;
    logic [LAT-1:0] v, d;
    logic [IW-1:0] ids [LAT];
    logic [OW-1:0] occ, occ_n;
    logic [FW-1:0] frames [N_REQ];
    logic cur_dir, launch, retire, drain_req;

    for (genvar k = 0; k < N_REQ; k++) begin : g_frames
        assign frames[k] = req_data[k*FW +: FW];
    end

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (.req(req_valid), .ptr(ptr), .grant(gnt), .idx(g));

    assign res_valid = v[LAT-1];
    assign res_id = ids[LAT-1];
    assign res_dir = d[LAT-1];
    assign res_data = hsn_data_out;
    assign hsn_en = !(res_valid && !res_ready);
    assign retire = res_valid && res_ready;
    // While draining, only the locked requester may be considered
    assign gsel = state == DRAIN ? lg : g;
    assign launch = !rst && hsn_en && req_valid[gsel] &&
                    (state == DRAIN ? occ == '0 : (occ == '0 || req_dir[gsel] == cur_dir));
    assign req_ready = launch ? N_REQ'(1) << gsel : '0;
    assign hsn_data_in = req_valid[gsel] ? frames[gsel] : '0;
    assign hsn_dir = (launch && occ == '0) ? req_dir[gsel] : cur_dir;
    assign occ_n = occ + OW'(launch) - OW'(retire);
    assign drain_req = |gnt && req_dir[g] != cur_dir && occ != '0;

    always_comb begin
        state_n = occ_n == '0 ? IDLE : RUN;
        if (state == DRAIN ? (req_valid[lg] && !launch) : drain_req)
            state_n = DRAIN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            v <= '0;
            d <= '0;
            occ <= '0;
            cur_dir <= 1'b0;
            ptr <= '0;
            lg <= '0;
        end else begin
            state <= state_n;
            occ <= occ_n;
            if (hsn_en) begin
                v <= {v[LAT-2:0], launch};
                d <= {d[LAT-2:0], hsn_dir};
            end
            if (launch) begin
                ptr <= gsel == IW'(N_REQ - 1) ? '0 : gsel + 1'b1;
                cur_dir <= hsn_dir;
            end
            if (state != DRAIN && drain_req)
                lg <= g;
        end
    end

    always_ff @(posedge clk) begin
        if (hsn_en) begin
            ids[0] <= gsel;
            for (int i = 1; i < LAT; i++)
                ids[i] <= ids[i-1];
        end
    end
endmodule

// File: tb/tb_hsn_sched.sv
// tb_hsn_sched: randomized and directed checks of hsn_sched against a frame-queue reference model
module tb_hsn_sched;
    localparam int DW = 32, NI = 8, NR = 4, LAT = 9, FW = DW * NI;

    logic clk = 1'b0, rst = 1'b1;
    logic [NR-1:0] req_valid = '0, req_dir = '0, req_ready;
    logic [NR*FW-1:0] req_data = '0;
    logic [FW-1:0] hsn_data_in, hsn_data_out, res_data;
    logic hsn_dir, hsn_en, res_valid, res_dir;
    logic res_ready = 1'b1;
    logic [1:0] res_id;

    always #5 clk = ~clk;

    hsn_sched dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_dir(req_dir), .req_data(req_data),
        .req_ready(req_ready), .hsn_data_in(hsn_data_in), .hsn_dir(hsn_dir), .hsn_en(hsn_en),
        .hsn_data_out(hsn_data_out), .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_dir(res_dir), .res_data(res_data)
    );

    // dir=0 sorts ascending from element 0, dir=1 descending
    function automatic logic [FW-1:0] sort_frame(input logic [FW-1:0] f, input logic dir);
        logic [DW-1:0] a [NI];
        logic [DW-1:0] t;
        logic [FW-1:0] r;
        for (int i = 0; i < NI; i++) a[i] = f[i*DW +: DW];
        for (int i = 0; i < NI - 1; i++)
            for (int j = 0; j < NI - 1 - i; j++)
                if (dir ? a[j] < a[j+1] : a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        for (int i = 0; i < NI; i++) r[i*DW +: DW] = a[i];
        return r;
    endfunction

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] r;
        for (int i = 0; i < NI; i++) r[i*DW +: DW] = $urandom % 64;
        return r;
    endfunction

    // Behavioural HSN stand-in: LAT-deep frozen-when-disabled pipeline
    logic [FW-1:0] pipe [LAT];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else if (hsn_en) begin
            pipe[0] <= sort_frame(hsn_data_in, hsn_dir);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign hsn_data_out = pipe[LAT-1];

    typedef struct {int id; logic dir; logic [FW-1:0] data; int age;} ent_t;
    ent_t q[$];
    int m_ptr = 0, m_lock = -1;
    logic m_dir = 1'b0;
    int checks = 0, failures = 0;
    logic [NR-1:0] e_ready;
    logic e_valid, e_en;
    int e_cand;

    function automatic void eval();
        int occ = q.size();
        e_valid = 1'b0;
        if (occ > 0) e_valid = q[0].age == LAT - 1;
        e_en = !(e_valid && !res_ready);
        e_cand = -1;
        if (m_lock >= 0) e_cand = m_lock;
        else for (int i = 0; i < NR; i++)
            if (e_cand < 0 && req_valid[(m_ptr + i) % NR]) e_cand = (m_ptr + i) % NR;
        e_ready = '0;
        if (!rst && e_cand >= 0 && e_en && req_valid[e_cand] &&
            (m_lock >= 0 ? occ == 0 : (occ == 0 || req_dir[e_cand] == m_dir)))
            e_ready[e_cand] = 1'b1;
    endfunction

    task automatic step();
        logic launch;
        int occ0;
        eval();
        @(posedge clk);
        launch = e_ready != '0;
        occ0 = q.size();
        if (rst) begin
            q.delete(); m_ptr = 0; m_dir = 1'b0; m_lock = -1;
        end else begin
            if (e_valid && res_ready) void'(q.pop_front());
            if (e_en) foreach (q[i]) q[i].age++;
            if (m_lock >= 0) begin
                if (launch || !req_valid[m_lock]) m_lock = -1;
            end else if (e_cand >= 0 && req_dir[e_cand] != m_dir && occ0 > 0) m_lock = e_cand;
            if (launch) begin
                if (occ0 == 0) m_dir = req_dir[e_cand];
                q.push_back('{e_cand, req_dir[e_cand], req_data[e_cand*FW +: FW], 0});
                m_ptr = (e_cand + 1) % NR;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '1; res_ready = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== '0) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        step(); step();
        rst = 1'b0; req_valid = '0;
        @(negedge clk);
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
        checks++; if (hsn_en !== 1'b1) begin failures++; $display("FAIL reset_hsn_en got=%b exp=1", hsn_en); end
        checks++; if (req_ready !== '0) begin failures++; $display("FAIL reset_idle_ready got=%b exp=0000", req_ready); end
        step();
    endtask

    task automatic test_single();
        int vals [NI] = '{7, 3, 0, 5, 1, 6, 2, 4};
        logic [FW-1:0] f, ex;
        int n = 0;
        for (int i = 0; i < NI; i++) begin f[i*DW +: DW] = vals[i]; ex[i*DW +: DW] = i; end
        req_data[0 +: FW] = f; req_dir = '0; req_valid = 4'b0001;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_accept got=%b exp=0001", req_ready); end
        step();
        req_valid = '0;
        while (n < 20) begin
            @(negedge clk);
            if (res_valid) break;
            n++;
            step();
        end
        checks++; if (n !== LAT - 1) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", n, LAT - 1); end
        checks++; if (res_id !== 2'd0) begin failures++; $display("FAIL single_id got=%0d exp=0", res_id); end
        checks++; if (res_dir !== 1'b0) begin failures++; $display("FAIL single_dir got=%b exp=0", res_dir); end
        checks++; if (res_data !== ex) begin failures++; $display("FAIL single_data got=%h exp=%h", res_data, ex); end
        step();
    endtask

    task automatic test_round_robin();
        int exp_ids[$];
        int p = m_ptr;
        res_ready = 1'b1; req_dir = '0;
        for (int c = 0; c < 12 + LAT + 2; c++) begin
            req_valid = c < 12 ? '1 : '0;
            for (int k = 0; k < NR; k++) req_data[k*FW +: FW] = rand_frame();
            @(negedge clk);
            if (c < 12) begin
                checks++;
                if (req_ready !== 4'(1 << ((p + c) % NR))) begin
                    failures++; $display("FAIL rr_grant cycle=%0d got=%b exp=%b", c, req_ready, 4'(1 << ((p + c) % NR)));
                end
                exp_ids.push_back((p + c) % NR);
            end
            if (res_valid) begin
                checks++;
                if (exp_ids.size() == 0 || res_id !== 2'(exp_ids[0])) begin
                    failures++; $display("FAIL rr_result_order got=%0d exp=%0d", res_id, exp_ids.size() ? exp_ids[0] : -1);
                end
                if (exp_ids.size() > 0) void'(exp_ids.pop_front());
            end
            step();
        end
        checks++; if (exp_ids.size() !== 0) begin failures++; $display("FAIL rr_all_returned got=%0d_missing exp=0", exp_ids.size()); end
    endtask

    task automatic test_dir_switch();
        logic [FW-1:0] f1 = rand_frame();
        int hs = 0, last_hs = -10, launch_c = -1, n = 0;
        res_ready = 1'b1; req_dir = '0; req_valid = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            req_data[0 +: FW] = rand_frame();
            @(negedge clk);
            checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL sw_fill got=%b exp=0001", req_ready); end
            step();
        end
        req_valid = 4'b0010; req_dir = 4'b0010; req_data[FW +: FW] = f1;
        for (int c = 0; c < 30 && launch_c < 0; c++) begin
            @(negedge clk);
            if (req_ready !== '0) begin
                launch_c = c;
                checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL sw_grant got=%b exp=0010", req_ready); end
                checks++; if (hsn_dir !== 1'b1) begin failures++; $display("FAIL sw_hsn_dir got=%b exp=1", hsn_dir); end
            end else if (res_valid && res_ready) begin
                hs++; last_hs = c;
            end
            step();
        end
        checks++; if (hs !== 3) begin failures++; $display("FAIL sw_retired got=%0d exp=3", hs); end
        checks++; if (launch_c !== last_hs + 1) begin failures++; $display("FAIL sw_penalty got=%0d exp=%0d", launch_c, last_hs + 1); end
        req_valid = '0;
        while (n < 20) begin
            @(negedge clk);
            if (res_valid) break;
            n++;
            step();
        end
        checks++; if (res_id !== 2'd1) begin failures++; $display("FAIL sw_res_id got=%0d exp=1", res_id); end
        checks++; if (res_dir !== 1'b1) begin failures++; $display("FAIL sw_res_dir got=%b exp=1", res_dir); end
        checks++; if (res_data !== sort_frame(f1, 1'b1)) begin failures++; $display("FAIL sw_res_data got=%h exp=%h", res_data, sort_frame(f1, 1'b1)); end
        step();
    endtask

    task automatic test_fairness();
        logic r3_early = 1'b0, got2 = 1'b0, got3 = 1'b0;
        res_ready = 1'b1; req_dir = '0; req_valid = 4'b0001;
        step(); step();
        req_valid = 4'b1100; req_dir = 4'b0100;
        for (int c = 0; c < 30 && !got2; c++) begin
            @(negedge clk);
            if (req_ready[3]) r3_early = 1'b1;
            if (req_ready[2]) got2 = 1'b1;
            step();
        end
        checks++; if (r3_early !== 1'b0) begin failures++; $display("FAIL fair_req3_blocked got=%b exp=0", r3_early); end
        checks++; if (got2 !== 1'b1) begin failures++; $display("FAIL fair_req2_granted got=%b exp=1", got2); end
        req_valid = 4'b1000;
        for (int c = 0; c < 30 && !got3; c++) begin
            @(negedge clk);
            if (req_ready[3]) got3 = 1'b1;
            step();
        end
        checks++; if (got3 !== 1'b1) begin failures++; $display("FAIL fair_req3_later got=%b exp=1", got3); end
        req_valid = '0;
        repeat (LAT + 3) step();
    endtask

    task automatic test_backpressure();
        logic [FW-1:0] cap;
        logic [1:0] cap_id;
        res_ready = 1'b1; req_dir = '0; req_valid = '1;
        repeat (LAT) step();
        res_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) begin
                cap = res_data; cap_id = res_id;
                checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL bp_full got=%b exp=1", res_valid); end
            end else begin
                checks++; if (res_data !== cap || res_id !== cap_id) begin failures++; $display("FAIL bp_stable got=%0d/%h exp=%0d/%h", res_id, res_data, cap_id, cap); end
            end
            checks++; if (hsn_en !== 1'b0) begin failures++; $display("FAIL bp_en got=%b exp=0", hsn_en); end
            checks++; if (req_ready !== '0) begin failures++; $display("FAIL bp_ready got=%b exp=0000", req_ready); end
            step();
        end
        res_ready = 1'b1; req_valid = '0;
        for (int c = 0; c < LAT; c++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || q.size() == 0 || res_id !== 2'(q[0].id)) begin
                failures++; $display("FAIL bp_release cycle=%0d got=%b/%0d exp=1/%0d", c, res_valid, res_id, q.size() ? q[0].id : -1);
            end
            step();
        end
        repeat (3) step();
    endtask

    task automatic test_reset_midflight();
        logic stale = 1'b0;
        res_ready = 1'b1; req_dir = '0; req_valid = 4'b0001;
        repeat (6) step();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== '0) begin failures++; $display("FAIL rst_ready_forced got=%b exp=0000", req_ready); end
        step();
        rst = 1'b0; req_valid = '0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (res_valid !== 1'b0) stale = 1'b1;
            step();
        end
        checks++; if (stale !== 1'b0) begin failures++; $display("FAIL rst_no_stale got=%b exp=0", stale); end
        req_valid = '1;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rst_ptr got=%b exp=0001", req_ready); end
        step();
        req_valid = '0;
        repeat (LAT + 3) step();
    endtask

    task automatic test_random();
        logic [NR-1:0] acc = '0;
        logic gdir = 1'b0;
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < NR; k++) begin
                if (!req_valid[k] || acc[k]) begin
                    req_valid[k] = $urandom % 2;
                    req_dir[k] = ($urandom % 8 == 0) ? !gdir : gdir;
                    req_data[k*FW +: FW] = rand_frame();
                end else if ($urandom % 16 == 0) req_valid[k] = 1'b0;
            end
            if ($urandom % 32 == 0) gdir = !gdir;
            res_ready = $urandom % 5 != 0;
            @(negedge clk);
            eval();
            checks++; if (req_ready !== e_ready) begin failures++; $display("FAIL rnd_ready cycle=%0d got=%b exp=%b", c, req_ready, e_ready); end
            checks++; if (hsn_en !== e_en) begin failures++; $display("FAIL rnd_en cycle=%0d got=%b exp=%b", c, hsn_en, e_en); end
            checks++; if (res_valid !== e_valid) begin failures++; $display("FAIL rnd_res_valid cycle=%0d got=%b exp=%b", c, res_valid, e_valid); end
            if (e_valid) begin
                checks++;
                if (res_id !== 2'(q[0].id) || res_dir !== q[0].dir || res_data !== sort_frame(q[0].data, q[0].dir)) begin
                    failures++; $display("FAIL rnd_result cycle=%0d got=%0d/%b/%h exp=%0d/%b/%h", c, res_id, res_dir, res_data, q[0].id, q[0].dir, sort_frame(q[0].data, q[0].dir));
                end
            end
            if (e_ready != '0) begin
                checks++;
                if (hsn_data_in !== req_data[e_cand*FW +: FW] || hsn_dir !== (q.size() == 0 ? req_dir[e_cand] : m_dir)) begin
                    failures++; $display("FAIL rnd_launch cycle=%0d got=%b/%h exp=%b/%h", c, hsn_dir, hsn_data_in, q.size() == 0 ? req_dir[e_cand] : m_dir, req_data[e_cand*FW +: FW]);
                end
            end
            acc = req_ready;
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_dir_switch();
        test_fairness();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
